// File: rtl/rle_pkg.sv
// Shared widths and FSM encoding for the run-length codec pair (rle_dec / rle_enc).
package rle_pkg;

    localparam int COUNT_W = 23;
    localparam int WORD_W  = 24;
    localparam int BYTE_W  = 8;
    localparam int IDX_W   = 4;

    localparam logic [COUNT_W-1:0] RUN_ONE  = COUNT_W'(1);
    localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(BYTE_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQUEST_INPUT,
        WAIT_INPUT,
        READ_INPUT,
        EMIT_BITS,
        REQUEST_OUTPUT,
        WAIT_OUTPUT,
        FLUSH
    } state_t;

endpackage

// File: rtl/rle_dec_if.sv
// FIFO-facing signals of the decoder: input-side read port and output-side write port.
interface rle_dec_if;
    import rle_pkg::*;

    logic                recv_ready;
    logic                send_ready;
    logic [WORD_W-1:0]   in_data;
    logic                end_of_stream;
    logic                rd_req;
    logic                wr_req;
    logic [BYTE_W-1:0]   out_data;

    modport master (
        input  recv_ready, send_ready, in_data, end_of_stream,
        output rd_req, wr_req, out_data
    );

    modport slave (
        output recv_ready, send_ready, in_data, end_of_stream,
        input  rd_req, wr_req, out_data
    );

endinterface

// File: rtl/rle_bit_packer.sv
// Byte assembler: inserts one bit per cycle LSB first; index counts 0..8.
// Single-cycle update; no flow control of its own, the decoder FSM gates i_ins.
module rle_bit_packer
    import rle_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_ins,
    input  logic              i_bit,
    output logic [BYTE_W-1:0] o_byte,
    output logic [IDX_W-1:0]  o_idx
);

    logic [BYTE_W-1:0] r_byte;
    logic [IDX_W-1:0]  r_idx;

    // Cleared buffer guarantees zero upper bits on a partial byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte <= '0;
            r_idx  <= '0;
        end else if (i_clr) begin
            r_byte <= '0;
            r_idx  <= '0;
        end else if (i_ins) begin
            r_byte[r_idx[IDX_W-2:0]] <= i_bit;
            r_idx                    <= r_idx + IDX_ONE;
        end
    end

    assign o_byte = r_byte;
    assign o_idx  = r_idx;

endmodule

// File: rtl/rle_dec.sv
// Run-length decoder: {value,length} words in, LSB-first bytes out via FIFO handshakes.
// 3 cycles per word fetch, 1 cycle per bit, 2 cycles per byte write; stalls while send_ready is low.
module rle_dec
    import rle_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    rle_dec_if.master bus
);

    state_t              r_state;
    state_t              w_nxt_state;
    logic                r_run_val;
    logic [COUNT_W-1:0]  r_run_rem;
    logic [BYTE_W-1:0]   r_out_data;
    logic                r_flush;

    logic                w_load_word;
    logic                w_emit;
    logic                w_clr;
    logic                w_load_out;
    logic                w_run_clr;
    logic                w_flush_set;
    logic                w_flush_clr;
    logic [BYTE_W-1:0]   w_byte;
    logic [IDX_W-1:0]    w_idx;

    rle_bit_packer u_packer (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_ins  (w_emit),
        .i_bit  (r_run_val),
        .o_byte (w_byte),
        .o_idx  (w_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nxt_state;
    end

    always_comb begin
        w_nxt_state = r_state;
        w_load_word = 1'b0;
        w_emit      = 1'b0;
        w_clr       = 1'b0;
        w_load_out  = 1'b0;
        w_run_clr   = 1'b0;
        w_flush_set = 1'b0;
        w_flush_clr = 1'b0;
        case (r_state)
            IDLE: begin
                w_clr       = 1'b1;
                w_run_clr   = 1'b1;
                w_flush_clr = 1'b1;
                w_nxt_state = REQUEST_INPUT;
            end
            REQUEST_INPUT: begin
                if (bus.recv_ready)         w_nxt_state = WAIT_INPUT;
                else if (bus.end_of_stream) w_nxt_state = (w_idx != '0) ? FLUSH : IDLE;
            end
            WAIT_INPUT: w_nxt_state = READ_INPUT;
            READ_INPUT: begin
                w_load_word = 1'b1;
                w_nxt_state = (bus.in_data[COUNT_W-1:0] == '0) ? REQUEST_INPUT : EMIT_BITS;
            end
            EMIT_BITS: begin
                w_emit = 1'b1;
                // A full byte takes precedence over an exhausted run.
                if (w_idx == IDX_LAST)          w_nxt_state = REQUEST_OUTPUT;
                else if (r_run_rem == RUN_ONE)  w_nxt_state = REQUEST_INPUT;
            end
            REQUEST_OUTPUT: begin
                if (bus.send_ready) begin
                    w_load_out  = 1'b1;
                    w_nxt_state = WAIT_OUTPUT;
                end
            end
            WAIT_OUTPUT: begin
                w_clr = 1'b1;
                if (r_flush) begin
                    w_flush_clr = 1'b1;
                    w_nxt_state = IDLE;
                end else begin
                    w_nxt_state = (r_run_rem != '0) ? EMIT_BITS : REQUEST_INPUT;
                end
            end
            FLUSH: begin
                w_flush_set = 1'b1;
                w_nxt_state = REQUEST_OUTPUT;
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_val  <= 1'b0;
            r_run_rem  <= '0;
            r_out_data <= '0;
            r_flush    <= 1'b0;
        end else begin
            if (w_run_clr) begin
                r_run_val <= 1'b0;
                r_run_rem <= '0;
            end else if (w_load_word) begin
                r_run_val <= bus.in_data[WORD_W-1];
                r_run_rem <= bus.in_data[COUNT_W-1:0];
            end else if (w_emit) begin
                r_run_rem <= r_run_rem - RUN_ONE;
            end
            if (w_load_out) r_out_data <= w_byte;
            if (w_flush_set)      r_flush <= 1'b1;
            else if (w_flush_clr) r_flush <= 1'b0;
        end
    end

    assign bus.rd_req   = (r_state == WAIT_INPUT);
    assign bus.wr_req   = (r_state == WAIT_OUTPUT);
    assign bus.out_data = r_out_data;

endmodule

// File: tb/tb_rle_dec.sv
// Bench for rle_dec: FIFO models around the decoder, expected bytes queued at stimulus time.
module tb_rle_dec;
    import rle_pkg::*;

    logic clk;
    logic rst;
    rle_dec_if ifc ();

    rle_dec dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WORD_W-1:0] in_q[$];
    logic [BYTE_W-1:0] exp_q[$];
    logic [BYTE_W-1:0] got_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int n_rd = 0;
    int rd_under = 0;
    logic [BYTE_W-1:0] last_byte;

    function automatic logic [WORD_W-1:0] mkw(input bit v, input int len);
        logic [31:0] l;
        l = len;
        return {v, l[COUNT_W-1:0]};
    endfunction

    // Input-side FIFO model: registered read, data appears the cycle after rd_req.
    initial begin
        forever begin
            @(negedge clk);
            if (ifc.rd_req === 1'b1) begin
                n_rd++;
                if (in_q.size() > 0) ifc.in_data = in_q.pop_front();
                else                 rd_under++;
            end
            ifc.recv_ready = (in_q.size() != 0);
        end
    end

    task automatic collect(input int n, input int budget, output bit to);
        int cyc = 0;
        to = 1'b0;
        got_q.delete();
        while (got_q.size() < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (ifc.wr_req === 1'b1) got_q.push_back(ifc.out_data);
        end
        if (got_q.size() < n) to = 1'b1;
        repeat (16) begin
            @(negedge clk);
            if (ifc.wr_req === 1'b1) got_q.push_back(ifc.out_data);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (ifc.rd_req !== 1'b0) begin n_bad++; $display("FAIL reset_rd_req got %b want 0", ifc.rd_req); end
        n_cmp++;
        if (ifc.wr_req !== 1'b0) begin n_bad++; $display("FAIL reset_wr_req got %b want 0", ifc.wr_req); end
        n_cmp++;
        if (ifc.out_data !== 8'h00) begin n_bad++; $display("FAIL reset_out_data got %h want 00", ifc.out_data); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single;
        int cyc = 0;
        int lat = 0;
        int extra = 0;
        logic [BYTE_W-1:0] e;
        logic [BYTE_W-1:0] g;
        exp_q.push_back(8'hFF);
        in_q.push_back(mkw(1'b1, 8));
        while (ifc.rd_req !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        do begin @(negedge clk); lat++; end while (ifc.wr_req !== 1'b1 && lat < 60);
        g = ifc.out_data;
        e = exp_q.pop_front();
        last_byte = e;
        n_cmp++;
        if (lat != 11) begin n_bad++; $display("FAIL single_latency got %0d want 11", lat); end
        n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL single_byte got %h want %h", g, e); end
        repeat (16) begin @(negedge clk); if (ifc.wr_req === 1'b1) extra++; end
        n_cmp++;
        if (extra != 0) begin n_bad++; $display("FAIL single_extra_wr got %0d want 0", extra); end
    endtask

    task automatic test_mixed;
        bit to;
        logic [BYTE_W-1:0] e;
        exp_q.push_back(8'hF8);
        in_q.push_back(mkw(1'b0, 3));
        in_q.push_back(mkw(1'b1, 5));
        collect(1, 200, to);
        n_cmp++;
        if (to || got_q.size() != 1) begin n_bad++; $display("FAIL mixed_count got %0d want 1", got_q.size()); end
        e = exp_q.pop_front();
        last_byte = e;
        n_cmp++;
        if (got_q.size() > 0 && got_q[0] !== e) begin n_bad++; $display("FAIL mixed_byte got %h want %h", got_q[0], e); end
    endtask

    task automatic test_back_to_back;
        bit to;
        logic [BYTE_W-1:0] e;
        exp_q.push_back(8'h0F);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h0F);
        in_q.push_back(mkw(1'b1, 4));
        in_q.push_back(mkw(1'b0, 4));
        in_q.push_back(mkw(1'b1, 12));
        in_q.push_back(mkw(1'b0, 4));
        collect(3, 400, to);
        n_cmp++;
        if (to || got_q.size() != 3) begin n_bad++; $display("FAIL b2b_count got %0d want 3", got_q.size()); end
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            last_byte = e;
            n_cmp++;
            if (i < got_q.size() && got_q[i] !== e) begin n_bad++; $display("FAIL b2b_byte%0d got %h want %h", i, got_q[i], e); end
        end
    endtask

    task automatic test_zero_len;
        bit to;
        int rd0;
        logic [BYTE_W-1:0] e;
        rd0 = n_rd;
        exp_q.push_back(8'h00);
        in_q.push_back(mkw(1'b1, 0));
        in_q.push_back(mkw(1'b0, 8));
        collect(1, 200, to);
        n_cmp++;
        if (to || got_q.size() != 1) begin n_bad++; $display("FAIL zero_count got %0d want 1", got_q.size()); end
        e = exp_q.pop_front();
        last_byte = e;
        n_cmp++;
        if (got_q.size() > 0 && got_q[0] !== e) begin n_bad++; $display("FAIL zero_byte got %h want %h", got_q[0], e); end
        n_cmp++;
        if (n_rd - rd0 != 2) begin n_bad++; $display("FAIL zero_rd_count got %0d want 2", n_rd - rd0); end
    endtask

    task automatic test_flush;
        int cyc = 0;
        int extra = 0;
        logic [BYTE_W-1:0] e;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h0F);
        in_q.push_back(mkw(1'b1, 20));
        while (ifc.rd_req !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        ifc.end_of_stream = 1'b1;
        got_q.delete();
        cyc = 0;
        while (got_q.size() < 3 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (ifc.wr_req === 1'b1) got_q.push_back(ifc.out_data);
        end
        n_cmp++;
        if (got_q.size() != 3) begin n_bad++; $display("FAIL flush_count got %0d want 3", got_q.size()); end
        @(negedge clk);
        n_cmp++;
        if (dut.r_state !== IDLE) begin n_bad++; $display("FAIL flush_idle got %0d want %0d", dut.r_state, IDLE); end
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            last_byte = e;
            n_cmp++;
            if (i < got_q.size() && got_q[i] !== e) begin n_bad++; $display("FAIL flush_byte%0d got %h want %h", i, got_q[i], e); end
        end
        repeat (16) begin @(negedge clk); if (ifc.wr_req === 1'b1) extra++; end
        ifc.end_of_stream = 1'b0;
        n_cmp++;
        if (extra != 0) begin n_bad++; $display("FAIL flush_extra_wr got %0d want 0", extra); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_backpressure;
        bit to;
        int wr_seen = 0;
        int held_bad = 0;
        logic [BYTE_W-1:0] e;
        ifc.send_ready = 1'b0;
        exp_q.push_back(8'hFF);
        in_q.push_back(mkw(1'b1, 8));
        repeat (30) begin
            @(negedge clk);
            if (ifc.wr_req === 1'b1) wr_seen++;
            if (ifc.out_data !== last_byte) held_bad++;
        end
        n_cmp++;
        if (wr_seen != 0) begin n_bad++; $display("FAIL bp_wr_while_stalled got %0d want 0", wr_seen); end
        n_cmp++;
        if (held_bad != 0) begin n_bad++; $display("FAIL bp_out_held got %0d changed cycles want 0", held_bad); end
        n_cmp++;
        if (dut.r_state !== REQUEST_OUTPUT) begin n_bad++; $display("FAIL bp_state got %0d want %0d", dut.r_state, REQUEST_OUTPUT); end
        ifc.send_ready = 1'b1;
        collect(1, 20, to);
        n_cmp++;
        if (to || got_q.size() != 1) begin n_bad++; $display("FAIL bp_count got %0d want 1", got_q.size()); end
        e = exp_q.pop_front();
        last_byte = e;
        n_cmp++;
        if (got_q.size() > 0 && got_q[0] !== e) begin n_bad++; $display("FAIL bp_byte got %h want %h", got_q[0], e); end
    endtask

    task automatic test_reset_mid;
        bit to;
        int cyc = 0;
        int extra = 0;
        logic [BYTE_W-1:0] e;
        in_q.push_back(mkw(1'b1, 8));
        while (ifc.rd_req !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ifc.out_data !== 8'h00) begin n_bad++; $display("FAIL rmid_out_data got %h want 00", ifc.out_data); end
        n_cmp++;
        if (ifc.wr_req !== 1'b0 || ifc.rd_req !== 1'b0) begin n_bad++; $display("FAIL rmid_req got wr=%b rd=%b want 0 0", ifc.wr_req, ifc.rd_req); end
        n_cmp++;
        if (dut.r_state !== IDLE) begin n_bad++; $display("FAIL rmid_state got %0d want %0d", dut.r_state, IDLE); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) begin @(negedge clk); if (ifc.wr_req === 1'b1) extra++; end
        n_cmp++;
        if (extra != 0) begin n_bad++; $display("FAIL rmid_extra_wr got %0d want 0", extra); end
        exp_q.push_back(8'h00);
        in_q.push_back(mkw(1'b0, 8));
        collect(1, 200, to);
        n_cmp++;
        if (to || got_q.size() != 1) begin n_bad++; $display("FAIL rmid_count got %0d want 1", got_q.size()); end
        e = exp_q.pop_front();
        n_cmp++;
        if (got_q.size() > 0 && got_q[0] !== e) begin n_bad++; $display("FAIL rmid_byte got %h want %h", got_q[0], e); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        ifc.recv_ready    = 1'b0;
        ifc.send_ready    = 1'b1;
        ifc.in_data       = '0;
        ifc.end_of_stream = 1'b0;
        last_byte         = 8'h00;
        test_reset();
        test_single();
        test_mixed();
        test_back_to_back();
        test_zero_len();
        test_flush();
        test_backpressure();
        test_reset_mid();
        n_cmp++;
        if (rd_under != 0) begin n_bad++; $display("FAIL rd_underflow got %0d want 0", rd_under); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rle_dec.md
RLE_DEC -- requirements
Module: rle_dec

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: recv_ready  in  1  input-side FIFO not empty.
REQ-004 SHALL have: send_ready  in  1  output-side FIFO not full.
REQ-005 SHALL have: in_data  in  24  encoded word; [23] bit value, [22:0] run length.
REQ-006 SHALL have: end_of_stream  in  1  no further words; flush partial byte.
REQ-007 SHALL have: rd_req  out  1  read request to input-side FIFO.
REQ-008 SHALL have: wr_req  out  1  write request to output-side FIFO.
REQ-009 SHALL have: out_data  out  8  decoded byte to output-side FIFO.

Function
REQ-010 SHALL implement states IDLE, REQUEST_INPUT, WAIT_INPUT, READ_INPUT, EMIT_BITS, REQUEST_OUTPUT, WAIT_OUTPUT, FLUSH.
REQ-011 IDLE SHALL clear byte buffer, bit index, run register; next state REQUEST_INPUT.
REQ-012 REQUEST_INPUT: recv_ready=1 -> WAIT_INPUT with rd_req high during WAIT_INPUT; recv_ready takes priority over end_of_stream.
REQ-013 REQUEST_INPUT with recv_ready=0 and end_of_stream=1 SHALL go to FLUSH if bit index != 0, else IDLE.
REQ-014 rd_req SHALL be high for exactly one cycle per word; in_data SHALL be sampled at the end of READ_INPUT (cycle after rd_req).
REQ-015 READ_INPUT SHALL latch run value = in_data[23], run remaining = in_data[22:0]; remaining=0 -> REQUEST_INPUT (word discarded, no bits emitted).
REQ-016 EMIT_BITS SHALL write run value into byte buffer bit [bit index], decrement remaining, increment bit index: one bit per cycle.
REQ-017 Bit order SHALL be LSB first: first decoded bit of a byte lands in out_data[0].
REQ-018 EMIT_BITS: bit index reaches 8 -> REQUEST_OUTPUT; else remaining reaches 0 -> REQUEST_INPUT; else stay.
REQ-019 REQUEST_OUTPUT SHALL wait while send_ready=0 holding byte buffer unchanged; send_ready=1 -> WAIT_OUTPUT with wr_req high during WAIT_OUTPUT.
REQ-020 wr_req SHALL be high exactly one cycle per byte; out_data SHALL be registered, valid during the wr_req cycle and held until the next byte is assembled.
REQ-021 After WAIT_OUTPUT: clear bit index and buffer; remaining != 0 -> EMIT_BITS, else REQUEST_INPUT.
REQ-022 FLUSH SHALL write the partial byte with unfilled upper bits zero, using the REQUEST_OUTPUT/WAIT_OUTPUT handshake, then go to IDLE.
REQ-023 Run length arithmetic SHALL be 23-bit unsigned; max run 2^23-1 decoded without overflow or wrap.
REQ-024 Throughput SHALL be 8 cycles per byte in steady state plus 3 cycles per word fetch and 2 cycles per byte write.

Reset
REQ-025 rst=1 SHALL asynchronously force state IDLE, rd_req=0, wr_req=0, out_data=0x00, bit index=0, remaining=0.
REQ-026 Reset mid-run or mid-handshake SHALL abandon the partial byte and remaining run with no further wr_req.

Structure
REQ-027 Package rle_pkg SHALL hold state encoding, COUNT_W=23, WORD_W=24, BYTE_W=8 shared with rle_enc.
REQ-028 One sub-module rle_bit_packer (byte buffer, bit index, LSB-first insert, clear) is natural; FSM stays in rle_dec.

Verification
REQ-029 Word {1,8} -> one wr_req, out_data=0xFF.
REQ-030 Words {0,3},{1,5} -> one byte 0xF8.
REQ-031 Word {1,20} then end_of_stream -> bytes 0xFF, 0xFF, 0x0F, then IDLE.
REQ-032 Words {1,0},{0,8} -> single byte 0x00; zero-length word produces no bits.
REQ-033 Word {1,8} with send_ready=0 for 10 cycles -> wr_req low throughout, then one wr_req with 0xFF.
REQ-034 rst asserted at 4th EMIT_BITS cycle of {1,8} -> outputs 0 immediately, no wr_req; next word {0,8} yields 0x00.
